// File: rtl/simon_encrypt.sv
// Iterative Simon 32/64 encryption core with valid/ready handshakes on both sides.
// Takes a 32-bit block plus the 512-bit round-key bundle from the key schedule.
// It applies one Feistel round per clock by default.
// Optional build macro SIMON_TWO_ROUND_EN unrolls two rounds per clock.
// ROUNDS must then be even.
// ROUNDS must lie in 1..32 for either build.
module simon_encrypt #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_total,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  ciphertext,
  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

`ifdef SIMON_TWO_ROUND_EN
  localparam logic [4:0] RcStep = 5'd2;
  localparam logic [4:0] RcLast = 5'(ROUNDS - 2);
`else
  localparam logic [4:0] RcStep = 5'd1;
  localparam logic [4:0] RcLast = 5'(ROUNDS - 1);
`endif

  state_e         state_q;
  logic [15:0]    x_q, y_q;
  logic [4:0]     rc_q;
  logic [511:0]   key_q;
  logic           out_valid_q;
  logic [31:0]    ct_q;

  logic [15:0]    x_nxt, y_nxt;

  // Simon round function: (x <<< 1 & x <<< 8) ^ x <<< 2 on 16-bit words.
  function automatic logic [15:0] simon_f(input logic [15:0] v);
    logic [15:0] r1, r2, r8;
    r1 = {v[14:0], v[15]};
    r2 = {v[13:0], v[15:14]};
    r8 = {v[7:0], v[15:8]};
    return (r1 & r8) ^ r2;
  endfunction

  // Next x/y after the round(s) applied on this edge, keyed from the captured bundle.
`ifdef SIMON_TWO_ROUND_EN
  logic [15:0] k_a, k_b, x_mid;
  logic [4:0]  rc_p1;

  always_comb begin
    rc_p1 = rc_q + 5'd1;
    k_a   = key_q[{rc_q, 4'b0000} +: 16];
    k_b   = key_q[{rc_p1, 4'b0000} +: 16];
    x_mid = y_q ^ simon_f(x_q) ^ k_a;
    // Second round: the intermediate y is the old x.
    x_nxt = x_q ^ simon_f(x_mid) ^ k_b;
    y_nxt = x_mid;
  end
`else
  logic [15:0] k_a;

  always_comb begin
    k_a   = key_q[{rc_q, 4'b0000} +: 16];
    x_nxt = y_q ^ simon_f(x_q) ^ k_a;
    y_nxt = x_q;
  end
`endif

  // Acceptance is gated off during reset so no block slips in on a reset edge.
  assign in_ready   = (state_q == StIdle) && !rst;
  assign busy       = (state_q != StIdle);
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;

  // Control FSM and datapath registers; ciphertext only updates on the final round.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      rc_q        <= '0;
      out_valid_q <= 1'b0;
      ct_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q     <= plaintext[31:16];
            y_q     <= plaintext[15:0];
            key_q   <= key_total;
            rc_q    <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          if (rc_q == RcLast) begin
            // rc holds here instead of wrapping; it is cleared on the next accept.
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            ct_q        <= {x_nxt, y_nxt};
          end else begin
            rc_q <= rc_q + RcStep;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_encrypt.sv
// Self-checking bench for simon_encrypt: scoreboard of model results plus directed scenarios.
`timescale 1ns/1ps
module tb_simon_encrypt;

  localparam int unsigned ROUNDS = 32;
`ifdef SIMON_TWO_ROUND_EN
  localparam int unsigned LAT = ROUNDS / 2;
`else
  localparam int unsigned LAT = ROUNDS;
`endif
  localparam logic [31:0] VecPt = 32'h65656877;
  localparam logic [31:0] VecCt = 32'hc69be9bb;
  localparam int unsigned Bound = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_total;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  ciphertext;
  logic         busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;
  logic [511:0] vec_key;

  simon_encrypt #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_total  (key_total),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Reference Simon 32/64 key expansion (sequence z0, read left to right).
  function automatic logic [511:0] expand_key(input logic [63:0] key);
    logic [15:0]  k[32];
    logic [15:0]  tmp;
    logic [61:0]  z;
    logic [511:0] r;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp  = rotr(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ rotr(tmp, 1);
      k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) r[16*i +: 16] = k[i];
    return r;
  endfunction

  function automatic logic [31:0] simon_model(input logic [31:0] pt, input logic [511:0] kt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < ROUNDS; r++) begin
      t = x;
      x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ kt[16*r +: 16];
      y = t;
    end
    return {x, y};
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(simon_model(plaintext, key_total));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got ciphertext %h, required no output", ciphertext);
        end else begin
          sb_exp = exp_q.pop_front();
          if (ciphertext !== sb_exp) begin
            errors++;
            $display("FAIL sb_ciphertext: got %h, required %h", ciphertext, sb_exp);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "time limit");
  end

  task automatic send_block(input logic [31:0] pt, input logic [511:0] kt, input bit keep,
                            output int unsigned acc);
    int n = 0;
    plaintext = pt;
    key_total = kt;
    in_valid  = 1'b1;
    while (!in_ready && n < Bound) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int unsigned n);
    n = 0;
    while (!out_valid && n < Bound) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL output_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key_total = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++;
    if (ciphertext !== 32'h0) begin errors++; $display("FAIL rst_ciphertext: got %h, required 0", ciphertext); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_high: got %b, required 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_low: got %b, required 1", in_ready); end
  endtask

  task automatic test_vector();
    int unsigned acc, n;
    out_ready = 1'b1;
    send_block(VecPt, vec_key, 1'b0, acc);
    wait_out(n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL vec_latency: got %0d cycles, required %0d", n, LAT); end
    checks++;
    if (ciphertext !== VecCt) begin errors++; $display("FAIL vec_ciphertext: got %h, required %h", ciphertext, VecCt); end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL vec_done_flags: busy=%b in_ready=%b, required busy=1 in_ready=0", busy, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL vec_after_hs: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int unsigned acc, n;
    logic [511:0] kt;
    logic [31:0]  want;
    kt   = expand_key(64'h0123_4567_89ab_cdef);
    want = simon_model(32'h1234abcd, kt);
    out_ready = 1'b0;
    send_block(32'h1234abcd, kt, 1'b0, acc);
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || ciphertext !== want || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b ct=%h in_ready=%b, required 1 %h 0",
                 i, out_valid, ciphertext, in_ready, want);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_key_capture();
    int unsigned acc, n;
    out_ready = 1'b1;
    send_block(VecPt, vec_key, 1'b0, acc);
    key_total = '0;
    wait_out(n);
    checks++;
    if (ciphertext !== VecCt) begin errors++; $display("FAIL key_capture: got %h, required %h", ciphertext, VecCt); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int unsigned acc, n;
    out_ready = 1'b1;
    send_block(32'hdeadbeef, vec_key, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: out_valid=%b busy=%b in_ready=%b, required 0 0 0",
               out_valid, busy, in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %b, required 0", out_valid); end
    end
    send_block(VecPt, vec_key, 1'b0, acc);
    wait_out(n);
    checks++;
    if (ciphertext !== VecCt || n !== LAT) begin
      errors++;
      $display("FAIL midrst_next: ct=%h latency=%0d, required %h %0d", ciphertext, n, VecCt, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int unsigned acc, prev, n;
    logic [511:0] kt;
    kt = {16{$urandom()}};
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send_block($urandom(), kt, (i < 3), acc);
      if (i > 0) begin
        checks++;
        if (acc - prev !== LAT + 2) begin
          errors++;
          $display("FAIL b2b_spacing: block %0d got %0d cycles, required %0d", i, acc - prev, LAT + 2);
        end
      end
      prev = acc;
    end
    wait_out(n);
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_input();
    int unsigned acc, n;
    logic [31:0] pt;
    pt = 32'h0f1e2d3c;
    out_ready = 1'b1;
    send_block(pt, vec_key, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    in_valid  = 1'b1;
    plaintext = ~pt;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready: got %b, required 0", in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out(n);
    checks++;
    if (ciphertext !== simon_model(pt, vec_key)) begin
      errors++;
      $display("FAIL ign_ciphertext: got %h, required %h", ciphertext, simon_model(pt, vec_key));
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_second_block: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  initial begin
    vec_key = expand_key(64'h1918_1110_0908_0100);
    test_reset();
    test_vector();
    test_backpressure();
    test_key_capture();
    test_mid_reset();
    test_back_to_back();
    test_ignored_input();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
